// File: rtl/apb_mem_slave_p.sv
// Purpose: parametrised APB scratch/config RAM slave with byte strobes, error response and error counter.
// Latency: 1 + WAIT_CYCLES cycles from the setup phase to Pready (zero-wait transfer is 2 cycles).
// Backpressure: wait states are inserted by holding Pready low; dropping Pselx mid-access aborts the transfer.
module apb_mem_slave_p #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 8
) (
    input  logic                  Pclk,
    input  logic                  Prst,
    input  logic [ADDR_W-1:0]     Paddr,
    input  logic                  Pselx,
    input  logic                  Penable,
    input  logic                  Pwrite,
    input  logic [DATA_W-1:0]     Pwdata,
    input  logic [DATA_W/8-1:0]   Pstrb,
    output logic                  Pready,
    output logic                  Pslverr,
    output logic [DATA_W-1:0]     Prdata,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    // Byte-address limit, one bit wider than Paddr so the compare cannot wrap.
    localparam logic [ADDR_W:0]   LIMIT      = (ADDR_W+1)'(DEPTH * NB);
    // Sub-word address bits; all-zero mask for 8-bit data (every address aligned).
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 write_q;
    logic                 err_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [NB-1:0]        strb_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [CNT_W-1:0]     err_cnt_q;
    logic [DATA_W-1:0]    mem [DEPTH];

    logic                 setup;
    logic                 complete;
    logic                 in_err;
    logic [IDX_W-1:0]     in_idx;
    logic                 ready;

    // Setup phase is recognised in either state; in ACCESS it restarts the transfer.
    assign setup    = Pselx && !Penable;
    assign in_idx   = Paddr[LSB +: IDX_W];
    assign in_err   = ((Paddr & ALIGN_MASK) != '0) || ({1'b0, Paddr} >= LIMIT);
    assign ready    = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign complete = ready && Pselx && Penable;

    // State register.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: IDLE -> ACCESS on setup; ACCESS exits on completion or abort.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (setup) state_d = ACCESS;
            ACCESS: begin
                if (!Pselx)                          state_d = IDLE;
                else if (Penable && cnt_q == 4'd0)   state_d = IDLE;
                else                                 state_d = ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are only meaningful on the Pready cycle, otherwise forced to zero.
    always_comb begin
        Pready  = ready;
        Pslverr = ready && err_q;
        Prdata  = (ready && !write_q && !err_q) ? rdata_q : '0;
        err_cnt = err_cnt_q;
    end

    // Capture the request on setup and count down wait states while the access phase is held.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
        end else if (setup) begin
            cnt_q   <= 4'(WAIT_CYCLES);
            idx_q   <= in_idx;
            write_q <= Pwrite;
            err_q   <= in_err;
            wdata_q <= Pwdata;
            strb_q  <= Pstrb;
            rdata_q <= (!Pwrite && !in_err) ? mem[in_idx] : '0;
        end else if (state_q == ACCESS && Pselx && Penable && cnt_q != 4'd0) begin
            cnt_q   <= cnt_q - 4'd1;
        end
    end

    // Memory array: only a completed, error-free write touches it, lane by lane.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (complete && write_q && !err_q) begin
            for (int b = 0; b < NB; b++) begin
                if (strb_q[b]) mem[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    // Saturating count of completed transfers that returned an error.
    always_ff @(posedge Pclk or negedge Prst) begin
        if (!Prst)                                    err_cnt_q <= '0;
        else if (complete && err_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
    end

endmodule
